// File: rtl/ahb_defslv_pkg.sv
// ahb_defslv_pkg: shared encodings for the AHB default slave.
// Holds the HTRANS/HRESP codes, the FSM state set and the wait-counter width.
package ahb_defslv_pkg;
    localparam int WAIT_CNT_W = 4;
    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;
    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01
    } hresp_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } state_e;
endpackage

// File: rtl/ahb_defslv_fault_capture.sv
// ahb_defslv_fault_capture: first-fault capture, saturating fault counter and irq.
// AHB_DEFSLV_OVERFLOW_EN adds a sticky overflow flag that also drives irq.
module ahb_defslv_fault_capture #(
    parameter int ADDR_WIDTH   = 32,
    parameter int MASTER_WIDTH = 4,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    invalid_i,
    input  logic                    clr_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    write_i,
    input  logic [MASTER_WIDTH-1:0] master_i,
    output logic                    valid_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    write_o,
    output logic [MASTER_WIDTH-1:0] master_o,
    output logic [CNT_WIDTH-1:0]    count_o,
    output logic                    overflow_o,
    output logic                    irq_o
);
    logic                    valid_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [MASTER_WIDTH-1:0] master_q;
    logic [CNT_WIDTH-1:0]    count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            master_q <= '0;
            count_q  <= '0;
        end else begin
            // a clear in the same cycle frees the capture slot for the new fault
            if (invalid_i && (!valid_q || clr_i)) begin
                addr_q   <= addr_i;
                write_q  <= write_i;
                master_q <= master_i;
            end
            valid_q <= invalid_i | (valid_q & ~clr_i);
            if (clr_i)
                count_q <= invalid_i ? CNT_WIDTH'(1) : '0;
            else if (invalid_i && count_q != '1)
                count_q <= count_q + 1'b1;
        end
    end

`ifdef AHB_DEFSLV_OVERFLOW_EN
    logic overflow_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            overflow_q <= 1'b0;
        else
            overflow_q <= clr_i ? 1'b0 : overflow_q | (invalid_i & valid_q);
    end
    assign overflow_o = overflow_q;
    assign irq_o      = valid_q | overflow_q;
`else
    assign overflow_o = 1'b0;
    assign irq_o      = valid_q;
`endif

    assign valid_o  = valid_q;
    assign addr_o   = addr_q;
    assign write_o  = write_q;
    assign master_o = master_q;
    assign count_o  = count_q;
endmodule

// File: rtl/ahb_default_slave_ext.sv
// ahb_default_slave_ext: AHB default slave issuing a two-cycle ERROR after WAIT_STATES waits.
// Optional macro AHB_DEFSLV_OVERFLOW_EN enables the sticky fault_overflow flag.
module ahb_default_slave_ext
    import ahb_defslv_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int MASTER_WIDTH = 4,
    parameter int WAIT_STATES  = 0,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [1:0]              HTRANS,
    input  logic                    HREADY,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic                    HWRITE,
    input  logic [MASTER_WIDTH-1:0] HMASTER,
    output logic                    HREADYOUT,
    output logic [1:0]              HRESP,
    input  logic                    fault_clr,
    output logic                    fault_valid,
    output logic [ADDR_WIDTH-1:0]   fault_addr,
    output logic                    fault_write,
    output logic [MASTER_WIDTH-1:0] fault_master,
    output logic [CNT_WIDTH-1:0]    fault_count,
    output logic                    fault_overflow,
    output logic                    irq
);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_e                 state_q;
    logic [WAIT_CNT_W-1:0]  wcnt_q;
    logic                   ready_q;
    logic [1:0]             resp_q;
    logic                   invalid;
    logic                   accept;

    assign invalid = HSEL & HREADY & (HTRANS == TRANS_NONSEQ || HTRANS == TRANS_SEQ);
    // only IDLE and ERR2 present HREADYOUT=1, so only they can take an address phase
    assign accept  = invalid & (state_q == ST_IDLE || state_q == ST_ERR2);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            ready_q <= 1'b1;
            resp_q  <= RESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERR2: begin
                    if (accept && WAIT_STATES > 0) begin
                        state_q <= ST_WAIT;
                        wcnt_q  <= WAIT_LOAD;
                        ready_q <= 1'b0;
                        resp_q  <= RESP_OKAY;
                    end else if (accept) begin
                        state_q <= ST_ERR1;
                        ready_q <= 1'b0;
                        resp_q  <= RESP_ERROR;
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= RESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q == '0) begin
                        state_q <= ST_ERR1;
                        resp_q  <= RESP_ERROR;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= RESP_ERROR;
                end
            endcase
        end
    end

    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;

    ahb_defslv_fault_capture #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MASTER_WIDTH(MASTER_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_capture (
        .clk_i     (HCLK),
        .rst_i     (HRESET),
        .invalid_i (accept),
        .clr_i     (fault_clr),
        .addr_i    (HADDR),
        .write_i   (HWRITE),
        .master_i  (HMASTER),
        .valid_o   (fault_valid),
        .addr_o    (fault_addr),
        .write_o   (fault_write),
        .master_o  (fault_master),
        .count_o   (fault_count),
        .overflow_o(fault_overflow),
        .irq_o     (irq)
    );
endmodule
